// File: rtl/data_pipe.sv
// Elastic register stage: DEPTH-entry buffer with valid/ready on both sides,
// synchronous flush, occupancy count and a registered refused-input pulse.
module data_pipe #(
    parameter int                WIDTH         = 32,
    parameter int                DEPTH         = 2,
    parameter logic [WIDTH-1:0]  REGISTER_INIT = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             drop;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1))
            return '0;
        return ptr + PTR_W'(1);
    endfunction

    assign o_ready = (count != CNT_W'(DEPTH));
    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;
    assign o_drop  = drop;

    assign push = i_valid & o_ready & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= REGISTER_INIT;
        end else begin
            drop <= i_valid & ~o_ready & ~i_flush;
            if (i_flush) begin
                // Storage is left as-is; only the bookkeeping is cleared.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= i_data;
                    wr_ptr      <= next_ptr(wr_ptr);
                end
                if (pop)
                    rd_ptr <= next_ptr(rd_ptr);
                count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_data_pipe.sv
// Scoreboard bench for data_pipe: a DEPTH=4 and a DEPTH=1 instance checked
// every cycle against a queue model of the buffer.
module tb_data_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] d4, d1;
    logic        vld4, vld1, rdy4, rdy1;
    logic        o_ready4, o_valid4, o_drop4;
    logic        o_ready1, o_valid1, o_drop1;
    logic [31:0] o_data4, o_data1;
    logic [2:0]  o_count4;
    logic [0:0]  o_count1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q4[$];
    logic [31:0] q1[$];
    logic        drop4_m = 1'b0;
    logic        drop1_m = 1'b0;
    logic        acc4, acc1;

    always #5 clk = ~clk;

    data_pipe #(.WIDTH(32), .DEPTH(4), .REGISTER_INIT(32'h0)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_data(d4), .i_valid(vld4),
        .o_ready(o_ready4), .o_data(o_data4), .o_valid(o_valid4), .i_ready(rdy4),
        .o_count(o_count4), .o_drop(o_drop4)
    );

    data_pipe #(.WIDTH(32), .DEPTH(1), .REGISTER_INIT(32'h0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_data(d1), .i_valid(vld1),
        .o_ready(o_ready1), .o_data(o_data1), .o_valid(o_valid1), .i_ready(rdy1),
        .o_count(o_count1), .o_drop(o_drop1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check outputs against the model, advance the model, then clock once.
    task automatic cycle();
        logic r4, v4, p4, r1, v1, p1;
        r4 = (q4.size() != 4);
        v4 = (q4.size() != 0);
        r1 = (q1.size() != 1);
        v1 = (q1.size() != 0);
        if (!rst) begin
            chk("rdy4",  32'(o_ready4), 32'(r4));
            chk("vld4",  32'(o_valid4), 32'(v4));
            chk("cnt4",  32'(o_count4), 32'(q4.size()));
            chk("drop4", 32'(o_drop4),  32'(drop4_m));
            if (v4) chk("data4", o_data4, q4[0]);
            chk("rdy1",  32'(o_ready1), 32'(r1));
            chk("vld1",  32'(o_valid1), 32'(v1));
            chk("cnt1",  32'(o_count1), 32'(q1.size()));
            chk("drop1", 32'(o_drop1),  32'(drop1_m));
            if (v1) chk("data1", o_data1, q1[0]);
        end
        acc4    = vld4 & r4 & ~flush & ~rst;
        p4      = v4 & rdy4 & ~flush & ~rst;
        drop4_m = vld4 & ~r4 & ~flush & ~rst;
        acc1    = vld1 & r1 & ~flush & ~rst;
        p1      = v1 & rdy1 & ~flush & ~rst;
        drop1_m = vld1 & ~r1 & ~flush & ~rst;
        if (rst || flush) begin
            q4.delete();
            q1.delete();
        end else begin
            if (p4) void'(q4.pop_front());
            if (acc4) q4.push_back(d4);
            if (p1) void'(q1.pop_front());
            if (acc1) q1.push_back(d1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        logic [31:0] words1 [3];
        rst = 1'b1; flush = 1'b0;
        vld4 = 1'b1; d4 = 32'hDEAD_BEEF; rdy4 = 1'b0;
        vld1 = 1'b1; d1 = 32'hDEAD_BEEF; rdy1 = 1'b1;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0; vld4 = 1'b0; vld1 = 1'b0;
        chk("rst_data4", o_data4, 32'h0);
        chk("rst_data1", o_data1, 32'h0);
        chk("rst_cnt4", 32'(o_count4), 32'h0);
        cycle();
        cycle();

        // Streaming 1..16 at one word per cycle.
        rdy4 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            vld4 = 1'b1; d4 = 32'(i);
            cycle();
        end
        vld4 = 1'b0;
        cycle();
        cycle();

        // Fill under backpressure, then drain.
        rdy4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld4 = 1'b1; d4 = 32'hA0 + 32'(i);
            cycle();
        end
        vld4 = 1'b0;
        chk("full_cnt4", 32'(o_count4), 32'd4);
        chk("full_rdy4", 32'(o_ready4), 32'd0);
        rdy4 = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Three buffered, then ten cycles of simultaneous push and pop.
        rdy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld4 = 1'b1; d4 = 32'hB0 + 32'(i);
            cycle();
        end
        rdy4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vld4 = 1'b1; d4 = 32'hC0 + 32'(i);
            cycle();
        end
        vld4 = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Flush with three buffered and a concurrent push/pop.
        rdy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld4 = 1'b1; d4 = 32'hD0 + 32'(i);
            cycle();
        end
        flush = 1'b1; vld4 = 1'b1; rdy4 = 1'b1; d4 = 32'hEE;
        cycle();
        flush = 1'b0; vld4 = 1'b0;
        chk("flush_cnt4", 32'(o_count4), 32'd0);
        chk("flush_drop4", 32'(o_drop4), 32'd0);
        vld4 = 1'b1; d4 = 32'hF0;
        cycle();
        vld4 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // DEPTH=1: upstream holds each word until accepted.
        words1[0] = 32'h55; words1[1] = 32'h66; words1[2] = 32'h77;
        rdy1 = 1'b1;
        for (int w = 0; w < 3; w++) begin
            vld1 = 1'b1; d1 = words1[w];
            waited = 0;
            acc1 = 1'b0;
            while (!acc1 && waited < 8) begin
                cycle();
                waited++;
            end
            if (!acc1) chk("d1_timeout", 32'(waited), 32'd0);
            if (w > 0) chk("d1_gap", 32'(waited), 32'd2);
        end
        vld1 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Mid-stream reset discards everything.
        rdy4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vld4 = 1'b1; d4 = 32'h90 + 32'(i);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0; vld4 = 1'b0; rdy4 = 1'b1;
        chk("rst2_data4", o_data4, 32'h0);
        for (int i = 0; i < 2; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
